// File: rtl/commit_register_file.sv
// ============================================================================
// Module   : commit_register_file
// Purpose  : General-purpose register file and status register written by the
//            writeback commit interface. Two register commit ports (result
//            and auto-increment), one PSR commit port, three combinational
//            read ports and a pending-write scoreboard for decode.
// Options  : COMMIT_REGFILE_BYPASS_EN - forward same-cycle commits to the
//            read ports (result > auto-increment > array).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_register_file #(
  parameter int NUM_REGS   = 16,
  parameter int WORD_WIDTH = 32,
  parameter int FLAG_WIDTH = 4,
  localparam int TAG_W     = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [TAG_W-1:0]      resultCommitRegTag,
  input  logic [WORD_WIDTH-1:0] resultCommitValue,
  input  logic [TAG_W-1:0]      autoIncCommitRegTag,
  input  logic [WORD_WIDTH-1:0] autoIncCommitValue,
  input  logic [FLAG_WIDTH-1:0] psrCommitValue,
  input  logic                  psrCommitEnable,
  input  logic [TAG_W-1:0]      readRegTagA,
  input  logic [TAG_W-1:0]      readRegTagB,
  input  logic [TAG_W-1:0]      readRegTagC,
  output logic [WORD_WIDTH-1:0] readValueA,
  output logic [WORD_WIDTH-1:0] readValueB,
  output logic [WORD_WIDTH-1:0] readValueC,
  output logic [FLAG_WIDTH-1:0] psrValue,
  input  logic [TAG_W-1:0]      issueRegTag,
  input  logic                  issueEnable,
  output logic [NUM_REGS-1:0]   pendingMask
);

  logic [WORD_WIDTH-1:0] regs_q [NUM_REGS];
  logic [WORD_WIDTH-1:0] regs_d [NUM_REGS];
  logic [FLAG_WIDTH-1:0] psr_q, psr_d;
  logic [NUM_REGS-1:0]   pend_q, pend_d;

  logic [TAG_W-1:0]      readTag [3];
  logic [WORD_WIDTH-1:0] readVal [3];

  // Next-state of the array: auto-increment first so the result port
  // overrides it when both commits name the same register.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (autoIncCommitRegTag != '0) begin
      regs_d[autoIncCommitRegTag] = autoIncCommitValue;
    end
    if (resultCommitRegTag != '0) begin
      regs_d[resultCommitRegTag] = resultCommitValue;
    end
    regs_d[0] = '0;
  end

  // PSR loads only on its strobe.
  always_comb begin
    psr_d = psr_q;
    if (psrCommitEnable) begin
      psr_d = psrCommitValue;
    end
  end

  // Scoreboard: commits clear, then an issue sets, so a re-issue of the
  // register being committed stays pending for the newer producer.
  always_comb begin
    pend_d = pend_q;
    pend_d[resultCommitRegTag]  = 1'b0;
    pend_d[autoIncCommitRegTag] = 1'b0;
    if (issueEnable) begin
      pend_d[issueRegTag] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      psr_q  <= '0;
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      psr_q  <= psr_d;
      pend_q <= pend_d;
    end
  end

  assign readTag[0] = readRegTagA;
  assign readTag[1] = readRegTagB;
  assign readTag[2] = readRegTagC;

  // Read ports: array contents, optionally overridden by same-cycle commits.
  // Tag 0 always reads zero and is never forwarded.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      readVal[p] = regs_q[readTag[p]];
`ifdef COMMIT_REGFILE_BYPASS_EN
      if (autoIncCommitRegTag != '0 && autoIncCommitRegTag == readTag[p]) begin
        readVal[p] = autoIncCommitValue;
      end
      if (resultCommitRegTag != '0 && resultCommitRegTag == readTag[p]) begin
        readVal[p] = resultCommitValue;
      end
`else
      // Array-only reads: a commit becomes visible after the next edge.
`endif
      if (readTag[p] == '0) begin
        readVal[p] = '0;
      end
    end
  end

  assign readValueA  = readVal[0];
  assign readValueB  = readVal[1];
  assign readValueC  = readVal[2];
  assign psrValue    = psr_q;
  assign pendingMask = pend_q;

endmodule

`default_nettype wire
